// File: rtl/fc_vector_io_pkg.sv
// Shared definitions for the FC network streaming endpoint: default
// geometry, inflight counter width and the TX state encoding.
package fc_vector_io_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_IN_VEC_LEN   = 6;
  localparam int DEF_OUT_VEC_LEN  = 3;
  localparam int DEF_MAX_INFLIGHT = 4;
  localparam int INFLIGHT_W       = 4;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_SEND = 1'b1
  } tx_state_t;

endpackage

// File: rtl/fc_vector_io_if.sv
// Streaming bus bundle between host, this endpoint and the FC network.
//
// Handshake rule for every valid/ready pair below except net_out: a beat
// transfers on a rising clk edge where valid and ready are both 1; the
// sender holds data/valid stable until that edge. net_out is a read-request
// port instead: net_out_ready is a request, and net_out_valid is a one-cycle
// pulse returned one cycle after a request that found the network FIFO
// non-empty.
interface fc_vector_io_if
  import fc_vector_io_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int IN_VEC_LEN  = DEF_IN_VEC_LEN,
  parameter int OUT_VEC_LEN = DEF_OUT_VEC_LEN
);

  logic [IN_VEC_LEN*DATA_WIDTH-1:0]  vec_in_data;
  logic                              vec_in_valid;
  logic                              vec_in_ready;
  logic [DATA_WIDTH-1:0]             net_in_data;
  logic                              net_in_valid;
  logic                              net_in_ready;
  logic [DATA_WIDTH-1:0]             net_out_data;
  logic                              net_out_valid;
  logic                              net_out_ready;
  logic [OUT_VEC_LEN*DATA_WIDTH-1:0] res_data;
  logic                              res_valid;
  logic                              res_ready;

  // Endpoint side
  modport slave (
    input  vec_in_data, vec_in_valid,
    output vec_in_ready,
    output net_in_data, net_in_valid,
    input  net_in_ready,
    input  net_out_data, net_out_valid,
    output net_out_ready,
    output res_data, res_valid,
    input  res_ready
  );

  // Host / network side
  modport master (
    output vec_in_data, vec_in_valid,
    input  vec_in_ready,
    input  net_in_data, net_in_valid,
    output net_in_ready,
    output net_out_data, net_out_valid,
    input  net_out_ready,
    input  res_data, res_valid,
    output res_ready
  );

endinterface

// File: rtl/fc_vector_io_result_collector.sv
// RX side: issues read requests to the network output FIFO and packs the
// returned words into one parallel result, held until the consumer takes it.
module fc_result_collector #(
  parameter int DATA_WIDTH  = 16,
  parameter int OUT_VEC_LEN = 3
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [DATA_WIDTH-1:0]             net_out_data_i,
  input  logic                              net_out_valid_i,
  output logic                              net_out_ready_o,
  output logic [OUT_VEC_LEN*DATA_WIDTH-1:0] res_data_o,
  output logic                              res_valid_o,
  input  logic                              res_ready_i,
  output logic                              overflow_err_o
);

  localparam int CW = $clog2(OUT_VEC_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(OUT_VEC_LEN - 1);

  logic [CW-1:0]                     cnt_q, cnt_d;
  logic                              rd_pending_q;
  logic                              res_valid_q, res_valid_d;
  logic [OUT_VEC_LEN*DATA_WIDTH-1:0] res_data_q, res_data_d;
  logic                              ovf_q, ovf_d;
  logic                              at_last;
  logic                              space;

  assign at_last = (cnt_q == LAST);
  assign space   = !res_valid_q && (cnt_q <= LAST);

  // Stop requesting once the final word may already be on its way back:
  // either a request is outstanding or the word is arriving now.
  assign net_out_ready_o = !rst && !res_valid_q
                           && !(at_last && rd_pending_q)
                           && !(at_last && net_out_valid_i);

  assign res_data_o     = res_data_q;
  assign res_valid_o    = res_valid_q;
  assign overflow_err_o = ovf_q;

  // Word capture, result hand-off and sticky overflow detection.
  always_comb begin
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    ovf_d       = ovf_q;
    if (res_valid_q && res_ready_i) begin
      res_valid_d = 1'b0;
    end
    if (net_out_valid_i) begin
      if (space) begin
        for (int w = 0; w < OUT_VEC_LEN; w++) begin
          if (cnt_q == CW'(w)) begin
            res_data_d[w*DATA_WIDTH +: DATA_WIDTH] = net_out_data_i;
          end
        end
        if (at_last) begin
          cnt_d       = '0;
          res_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  // Collector state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      rd_pending_q <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      ovf_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      rd_pending_q <= net_out_ready_o;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      ovf_q        <= ovf_d;
    end
  end

endmodule

// File: rtl/fc_vector_io.sv
// Host-side endpoint: serializes input vectors into the network, collects
// results, and limits frames in flight so network FIFOs cannot overrun.
module fc_vector_io
  import fc_vector_io_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int IN_VEC_LEN   = DEF_IN_VEC_LEN,
  parameter int OUT_VEC_LEN  = DEF_OUT_VEC_LEN,
  parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT
) (
  input  logic                  clk,
  input  logic                  rst,
  fc_vector_io_if.slave         bus,
  output logic                  busy,
  output logic [INFLIGHT_W-1:0] inflight,
  output logic                  overflow_err,
  output tx_state_t             tx_state_o
);

  localparam int IW = (IN_VEC_LEN > 1) ? $clog2(IN_VEC_LEN) : 1;
  localparam logic [IW-1:0]         LAST_IDX = IW'(IN_VEC_LEN - 1);
  localparam logic [INFLIGHT_W-1:0] MAX_F    = INFLIGHT_W'(MAX_INFLIGHT);

  tx_state_t                        state_q, state_d;
  logic [IW-1:0]                    idx_q, idx_d;
  logic [IN_VEC_LEN*DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [INFLIGHT_W-1:0]            inflight_q, inflight_d;
  logic                             vec_ready;
  logic                             accept;
  logic                             release_res;
  logic                             res_valid;

  assign vec_ready   = !rst && (state_q == T_IDLE) && (inflight_q < MAX_F);
  assign accept      = vec_ready && bus.vec_in_valid;
  assign release_res = res_valid && bus.res_ready;

  assign bus.vec_in_ready = vec_ready;
  assign bus.net_in_valid = (state_q == T_SEND);
  assign bus.net_in_data  = shreg_q[DATA_WIDTH-1:0];
  assign bus.res_valid    = res_valid;
  assign busy             = (state_q != T_IDLE) || (inflight_q != '0);
  assign inflight         = inflight_q;
  assign tx_state_o       = state_q;

  // TX next state: latch a vector, then shift one element out per transfer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    case (state_q)
      T_IDLE: begin
        if (accept) begin
          shreg_d = bus.vec_in_data;
          idx_d   = '0;
          state_d = T_SEND;
        end
      end
      T_SEND: begin
        if (bus.net_in_ready) begin
          shreg_d = shreg_q >> DATA_WIDTH;
          idx_d   = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            state_d = T_IDLE;
          end
        end
      end
      default: state_d = T_IDLE;
    endcase
  end

  // Frames outstanding: up on accept, down on result release.
  always_comb begin
    inflight_d = inflight_q;
    case ({accept, release_res})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  // TX and inflight registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= T_IDLE;
      idx_q      <= '0;
      shreg_q    <= '0;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      inflight_q <= inflight_d;
    end
  end

  fc_result_collector #(
    .DATA_WIDTH  (DATA_WIDTH),
    .OUT_VEC_LEN (OUT_VEC_LEN)
  ) u_collector (
    .clk             (clk),
    .rst             (rst),
    .net_out_data_i  (bus.net_out_data),
    .net_out_valid_i (bus.net_out_valid),
    .net_out_ready_o (bus.net_out_ready),
    .res_data_o      (bus.res_data),
    .res_valid_o     (res_valid),
    .res_ready_i     (bus.res_ready),
    .overflow_err_o  (overflow_err)
  );

endmodule

// File: tb/tb_fc_vector_io.sv
// Bench for fc_vector_io: directed frames through a behavioural network
// model, with element and result scoreboards checked by monitors.
module tb_fc_vector_io;
  import fc_vector_io_pkg::*;

  localparam int DW    = 16;
  localparam int N_IN  = 6;
  localparam int N_OUT = 3;
  localparam int MAXF  = 4;
  localparam int VW    = DW * N_IN;
  localparam int RW    = DW * N_OUT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fc_vector_io_if #(.DATA_WIDTH(DW), .IN_VEC_LEN(N_IN), .OUT_VEC_LEN(N_OUT)) bus ();

  logic            busy;
  logic [3:0]      inflight;
  logic            overflow_err;
  tx_state_t       tx_state;

  fc_vector_io #(
    .DATA_WIDTH   (DW),
    .IN_VEC_LEN   (N_IN),
    .OUT_VEC_LEN  (N_OUT),
    .MAX_INFLIGHT (MAXF)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .inflight     (inflight),
    .overflow_err (overflow_err),
    .tx_state_o   (tx_state)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [RW-1:0] exp_res_q[$];
  logic [DW-1:0] fifo_q[$];
  int   rd_reqs = 0;
  logic force_stray = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Element monitor: every transfer into the network must match the next expected element.
  logic [DW-1:0] el_e;
  always @(negedge clk) begin
    if (!rst && bus.net_in_valid && bus.net_in_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_element: got %0h expected none", bus.net_in_data);
      end else begin
        el_e = exp_q.pop_front();
        chk("element", bus.net_in_data, el_e);
      end
    end
  end

  // Result monitor: every released result must match the next expected packing.
  logic [RW-1:0] res_e;
  always @(negedge clk) begin
    if (!rst && bus.res_valid && bus.res_ready) begin
      if (exp_res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0h expected none", bus.res_data);
      end else begin
        res_e = exp_res_q.pop_front();
        chk("result", bus.res_data, res_e);
      end
    end
  end

  // Network output FIFO model: word returned one cycle after a granted request.
  initial begin : net_model
    bit req;
    bit stray;
    bus.net_out_valid = 1'b0;
    bus.net_out_data  = '0;
    forever begin
      @(negedge clk);
      req   = (rst === 1'b0) && (bus.net_out_ready === 1'b1) && (fifo_q.size() > 0);
      stray = force_stray;
      @(posedge clk);
      #1;
      if (req) begin
        bus.net_out_valid = 1'b1;
        bus.net_out_data  = fifo_q.pop_front();
        rd_reqs++;
      end else if (stray) begin
        bus.net_out_valid = 1'b1;
        bus.net_out_data  = 16'hDEAD;
        force_stray       = 1'b0;
      end else begin
        bus.net_out_valid = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] mkvec(input logic [DW-1:0] b);
    logic [VW-1:0] v;
    for (int e = 0; e < N_IN; e++) v[e*DW +: DW] = b + DW'(e);
    return v;
  endfunction

  task automatic send_try(input logic [VW-1:0] v, input int budget, output bit ok);
    ok = 1'b0;
    bus.vec_in_data  = v;
    bus.vec_in_valid = 1'b1;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (bus.vec_in_ready) ok = 1'b1;
      tick();
    end
    bus.vec_in_valid = 1'b0;
    if (ok) begin
      for (int e = 0; e < N_IN; e++) exp_q.push_back(v[e*DW +: DW]);
    end
  endtask

  task automatic push_result(input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                             input logic [DW-1:0] w2);
    fifo_q.push_back(w0);
    fifo_q.push_back(w1);
    fifo_q.push_back(w2);
    exp_res_q.push_back({w2, w1, w0});
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (inflight == 0 && !busy && exp_res_q.size() == 0 && exp_q.size() == 0) done = 1'b1;
    end
    chk(name, done, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    @(negedge clk);
    chk({tag, "_vec_in_ready"},  bus.vec_in_ready, 0);
    chk({tag, "_net_in_valid"},  bus.net_in_valid, 0);
    chk({tag, "_net_in_data"},   bus.net_in_data, 0);
    chk({tag, "_net_out_ready"}, bus.net_out_ready, 0);
    chk({tag, "_res_valid"},     bus.res_valid, 0);
    chk({tag, "_res_data"},      bus.res_data, 0);
    chk({tag, "_busy"},          busy, 0);
    chk({tag, "_inflight"},      inflight, 0);
    chk({tag, "_overflow"},      overflow_err, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin : main
    bit ok;
    int n;
    int acc;
    int rd0;
    bit seen;

    rst              = 1'b1;
    bus.vec_in_valid = 1'b0;
    bus.vec_in_data  = '0;
    bus.net_in_ready = 1'b1;
    bus.res_ready    = 1'b1;
    repeat (3) tick();
    check_zero("reset");
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_vec_in_ready", bus.vec_in_ready, 1);
    tick();

    // Single frame, all readies high
    send_try(mkvec(16'd1), 20, ok);
    chk("t1_accept", ok, 1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin
        chk("t1_first_valid", bus.net_in_valid, 1);
        chk("t1_first_data", bus.net_in_data, 16'd1);
      end
      if (bus.vec_in_ready) break;
      n++;
    end
    chk("t1_ready_gap", n, N_IN);
    fifo_q.push_back(16'h0010);
    fifo_q.push_back(16'h0020);
    fifo_q.push_back(16'h0030);
    exp_res_q.push_back(48'h0030_0020_0010);
    wait_idle("t1_idle", 60);
    chk("t1_busy", busy, 0);
    chk("t1_inflight", inflight, 0);
    tick();

    // Input backpressure on element 2
    send_try(mkvec(16'h0011), 20, ok);
    chk("t2_accept", ok, 1);
    tick();
    tick();
    bus.net_in_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_hold_valid", bus.net_in_valid, 1);
      chk("t2_hold_data", bus.net_in_data, 16'h0013);
      tick();
    end
    bus.net_in_ready = 1'b1;
    push_result(16'h0111, 16'h0222, 16'h0333);
    wait_idle("t2_idle", 80);
    tick();

    // Admission limit with results held back
    bus.res_ready = 1'b0;
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      send_try(mkvec(DW'(16'h0100 * (k + 1))), 15, ok);
      if (ok) acc++;
    end
    chk("t3_accepted", acc, MAXF);
    @(negedge clk);
    chk("t3_vec_in_ready", bus.vec_in_ready, 0);
    chk("t3_inflight", inflight, MAXF);

    // Output stall: two frames of words waiting, consumer not ready
    rd0 = rd_reqs;
    push_result(16'h0a01, 16'h0a02, 16'h0a03);
    push_result(16'h0b01, 16'h0b02, 16'h0b03);
    repeat (10) tick();
    @(negedge clk);
    chk("t4_net_out_ready", bus.net_out_ready, 0);
    chk("t4_reads", rd_reqs - rd0, N_OUT);
    chk("t4_fifo_left", fifo_q.size(), N_OUT);
    chk("t4_overflow", overflow_err, 0);
    chk("t4_res_valid", bus.res_valid, 1);
    tick();
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    @(negedge clk);
    chk("t3_inflight_after_release", inflight, MAXF - 1);
    tick();
    send_try(mkvec(16'h0600), 15, ok);
    chk("t3_fifth_accept", ok, 1);
    push_result(16'h0c01, 16'h0c02, 16'h0c03);
    push_result(16'h0d01, 16'h0d02, 16'h0d03);
    push_result(16'h0e01, 16'h0e02, 16'h0e03);
    bus.res_ready = 1'b1;
    wait_idle("t4_idle", 300);
    tick();

    // Stray pulse while a result is held
    bus.res_ready = 1'b0;
    send_try(mkvec(16'h0700), 20, ok);
    chk("t5_accept", ok, 1);
    push_result(16'h0071, 16'h0072, 16'h0073);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (bus.res_valid) seen = 1'b1;
    end
    chk("t5_res_valid", seen, 1);
    chk("t5_overflow_before", overflow_err, 0);
    tick();
    force_stray = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("t5_overflow", overflow_err, 1);
    chk("t5_res_hold", bus.res_data, 48'h0073_0072_0071);
    chk("t5_res_valid_hold", bus.res_valid, 1);
    tick();
    bus.res_ready = 1'b1;
    wait_idle("t5_idle", 60);
    chk("t5_overflow_sticky", overflow_err, 1);
    tick();

    // Reset during element 3 of a frame
    send_try(mkvec(16'h0800), 20, ok);
    chk("t6_accept", ok, 1);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_zero("t6_reset");
    exp_q.delete();
    exp_res_q.delete();
    fifo_q.delete();
    tick();
    rst = 1'b0;
    tick();
    send_try(mkvec(16'h0900), 20, ok);
    chk("t6_fresh_accept", ok, 1);
    push_result(16'h0091, 16'h0092, 16'h0093);
    wait_idle("t6_idle", 80);
    chk("t6_overflow", overflow_err, 0);

    chk("end_elem_q_empty", exp_q.size(), 0);
    chk("end_res_q_empty", exp_res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
